// File: rtl/seg7_scan_decoder.sv
// Purpose : reads back a multiplexed 7-segment display bus. It synchronizes and
//           debounces the segment/digit-select lines, decodes each digit to BCD,
//           and assembles hundreds/tens/units into a binary value.
// Ports   : clk, rst (sync, active-high); seg_in[7:0] (a..g, DP ignored);
//           dig_sel_n[2:0] (active-low digit selects); bcd_out, value_out,
//           valid (frame pulse), digit_err, overflow, sel_err (pulse).
module seg7_scan_decoder #(
  parameter int STABLE_CYCLES  = 16,   // legal range 2..255
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  seg_in,
  input  logic [2:0]  dig_sel_n,
  output logic [11:0] bcd_out,
  output logic [9:0]  value_out,
  output logic        valid,
  output logic        digit_err,
  output logic        overflow,
  output logic        sel_err
);

  localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES);

  // Slot indices inside the frame.
  localparam logic [1:0] SLOT_U = 2'd0;
  localparam logic [1:0] SLOT_T = 2'd1;
  localparam logic [1:0] SLOT_H = 2'd2;

  typedef enum logic {
    S_WAIT = 1'b0,
    S_HOLD = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------
  // Segment pattern decode: gfedcba (active-high) -> {ok, nibble}.
  // Undecodable patterns return ok=0 with a zero nibble.
  // ---------------------------------------------------------------------------
  function automatic logic [4:0] seg_decode(input logic [6:0] pat);
    logic [4:0] r;
    case (pat)
      7'h3F:   r = {1'b1, 4'd0};
      7'h06:   r = {1'b1, 4'd1};
      7'h5B:   r = {1'b1, 4'd2};
      7'h4F:   r = {1'b1, 4'd3};
      7'h66:   r = {1'b1, 4'd4};
      7'h6D:   r = {1'b1, 4'd5};
      7'h7D:   r = {1'b1, 4'd6};
      7'h07:   r = {1'b1, 4'd7};
      7'h7F:   r = {1'b1, 4'd8};
      7'h6F:   r = {1'b1, 4'd9};
      default: r = {1'b0, 4'd0};
    endcase
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Input stage. Both segments and selects are normalized to active-high
  // *before* the synchronizer, so the all-zero reset state of the flops reads
  // as "blank select, no segments lit" rather than as an illegal select.
  // ---------------------------------------------------------------------------
  logic [6:0] seg_norm;
  logic [2:0] sel_act;
  logic       unused_dp;

  assign seg_norm  = SEG_ACTIVE_LOW ? ~seg_in[6:0] : seg_in[6:0];
  assign sel_act   = ~dig_sel_n;
  assign unused_dp = seg_in[7];

  // Sample layout: {sel[2:0], seg[6:0]}
  logic [9:0] sync1_q;
  logic [9:0] sync2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= {sel_act, seg_norm};
      sync2_q <= sync1_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Stability filter. sync1_q is the synced sample that becomes current on
  // the next edge; comparing it with sync2_q lets cnt_q count consecutive
  // identical synced samples (the first one counts as 1).
  // ---------------------------------------------------------------------------
  logic       sample_match;
  logic [7:0] cnt_q;
  logic [7:0] cnt_next;

  assign sample_match = (sync1_q == sync2_q);

  always_comb begin
    cnt_next = 8'd1;
    if (sample_match) begin
      if (cnt_q >= CNT_MAX) begin
        cnt_next = CNT_MAX;
      end else begin
        cnt_next = cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Capture FSM: state register / next-state / outputs.
  // ---------------------------------------------------------------------------
  state_t state_q;
  state_t state_d;
  logic   capture;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_WAIT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_WAIT: if (cnt_next == CNT_MAX) state_d = S_HOLD;
      S_HOLD: if (!sample_match)        state_d = S_WAIT;
      default:                          state_d = S_WAIT;
    endcase
  end

  // One capture per stable period; the saturating counter cannot re-hit
  // CNT_MAX in WAIT without a mismatch first resetting it.
  always_comb begin
    capture = 1'b0;
    if (state_q == S_WAIT && cnt_next == CNT_MAX) begin
      capture = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Capture action: classify the select and decode the pattern being captured.
  // ---------------------------------------------------------------------------
  logic [2:0] cap_sel;
  logic [6:0] cap_seg;
  logic [4:0] cap_dec;
  logic [1:0] slot_idx;
  logic       slot_hit;
  logic       sel_illegal;

  assign cap_sel = sync1_q[9:7];
  assign cap_seg = sync1_q[6:0];
  assign cap_dec = seg_decode(cap_seg);

  always_comb begin
    slot_idx    = SLOT_U;
    slot_hit    = 1'b0;
    sel_illegal = 1'b0;
    case (cap_sel)
      3'b000: ;                                    // blank phase
      3'b001: begin slot_idx = SLOT_U; slot_hit = 1'b1; end
      3'b010: begin slot_idx = SLOT_T; slot_hit = 1'b1; end
      3'b100: begin slot_idx = SLOT_H; slot_hit = 1'b1; end
      default: sel_illegal = 1'b1;                 // two or more selects low
    endcase
  end

  // ---------------------------------------------------------------------------
  // Frame assembly. A digit seen twice in one frame is simply overwritten.
  // ---------------------------------------------------------------------------
  logic [2:0][3:0] dig_q;
  logic [2:0]      seen_q;
  logic [2:0]      err_q;
  logic            frame_done;

  assign frame_done = &seen_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      dig_q  <= '0;
      seen_q <= '0;
      err_q  <= '0;
    end else begin
      if (frame_done) begin
        seen_q <= '0;
        err_q  <= '0;
      end
      // Captures are at least STABLE_CYCLES apart, so this never collides
      // with frame_done in practice; if it did, the new digit survives.
      if (capture && slot_hit) begin
        dig_q[slot_idx]  <= cap_dec[3:0];
        seen_q[slot_idx] <= 1'b1;
        err_q[slot_idx]  <= ~cap_dec[4];
      end
    end
  end

  // h*100 + t*10 + u; the 10-bit result covers 0..999 exactly.
  logic [9:0] frame_value;

  assign frame_value = ({6'd0, dig_q[SLOT_H]} * 10'd100)
                     + ({6'd0, dig_q[SLOT_T]} * 10'd10)
                     +  {6'd0, dig_q[SLOT_U]};

  // ---------------------------------------------------------------------------
  // Output registers. Data outputs hold between frames; valid and sel_err
  // are single-cycle pulses.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      bcd_out   <= '0;
      value_out <= '0;
      valid     <= 1'b0;
      digit_err <= 1'b0;
      overflow  <= 1'b0;
      sel_err   <= 1'b0;
    end else begin
      valid   <= frame_done;
      sel_err <= capture & sel_illegal;
      if (frame_done) begin
        bcd_out   <= {dig_q[SLOT_H], dig_q[SLOT_T], dig_q[SLOT_U]};
        value_out <= frame_value;
        digit_err <= |err_q;
        overflow  <= (frame_value > 10'd255);
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Purpose : directed bench for seg7_scan_decoder (STABLE_CYCLES=16, active-low
//           segments). Drives digit phases, counts valid/sel_err pulses and
//           checks frame contents against hand-computed values.
module tb_seg7_scan_decoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  seg_in = 8'hFF;
  logic [2:0]  dig_sel_n = 3'b111;
  logic [11:0] bcd_out;
  logic [9:0]  value_out;
  logic        valid;
  logic        digit_err;
  logic        overflow;
  logic        sel_err;

  int checks   = 0;
  int failures = 0;

  int vcount  = 0;
  int secount = 0;
  int run     = 0;
  int maxrun  = 0;

  always #5 clk = ~clk;

  seg7_scan_decoder #(
    .STABLE_CYCLES (16),
    .SEG_ACTIVE_LOW(1'b1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .seg_in   (seg_in),
    .dig_sel_n(dig_sel_n),
    .bcd_out  (bcd_out),
    .value_out(value_out),
    .valid    (valid),
    .digit_err(digit_err),
    .overflow (overflow),
    .sel_err  (sel_err)
  );

  // Pulse monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (valid === 1'b1) begin
      vcount = vcount + 1;
      run    = run + 1;
      if (run > maxrun) maxrun = run;
    end else begin
      run = 0;
    end
    if (sel_err === 1'b1) secount = secount + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      failures = failures + 1;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one display phase (pattern given active-high gfedcba) for n cycles.
  task automatic phase(input logic [2:0] sel, input logic [6:0] pat, input int n);
    dig_sel_n = sel;
    seg_in    = {1'b1, ~pat};
    repeat (n) @(negedge clk);
  endtask

  initial begin
    // Reset held 3 cycles
    repeat (3) @(negedge clk);
    check("rst_bcd",   32'(bcd_out),   32'h0);
    check("rst_value", 32'(value_out), 32'h0);
    check("rst_valid", 32'(valid),     32'h0);
    check("rst_derr",  32'(digit_err), 32'h0);
    check("rst_ovf",   32'(overflow),  32'h0);
    check("rst_selerr",32'(sel_err),   32'h0);
    rst = 1'b0;
    phase(3'b111, 7'h00, 40);
    check("idle_valid_cnt",  32'(vcount),  32'd0);
    check("idle_selerr_cnt", 32'(secount), 32'd0);

    // Scan "123"
    phase(3'b110, 7'h4F, 40);
    phase(3'b101, 7'h5B, 40);
    phase(3'b011, 7'h06, 40);
    phase(3'b111, 7'h00, 40);
    check("s123_vcnt",  32'(vcount),    32'd1);
    check("s123_bcd",   32'(bcd_out),   32'h123);
    check("s123_value", 32'(value_out), 32'd123);
    check("s123_derr",  32'(digit_err), 32'h0);
    check("s123_ovf",   32'(overflow),  32'h0);

    // Glitch inside units phase: 7F for 5 cycles then back to 4F
    phase(3'b110, 7'h4F, 20);
    phase(3'b110, 7'h7F, 5);
    phase(3'b110, 7'h4F, 20);
    check("glitch_no_extra_valid", 32'(vcount), 32'd1);
    phase(3'b101, 7'h5B, 40);
    phase(3'b011, 7'h06, 40);
    phase(3'b111, 7'h00, 40);
    check("glitch_vcnt", 32'(vcount),  32'd2);
    check("glitch_bcd",  32'(bcd_out), 32'h123);

    // Invalid units pattern with tens=5, hundreds=2
    phase(3'b110, 7'h49, 40);
    phase(3'b101, 7'h6D, 40);
    phase(3'b011, 7'h5B, 40);
    phase(3'b111, 7'h00, 40);
    check("inv_vcnt",  32'(vcount),    32'd3);
    check("inv_bcd",   32'(bcd_out),   32'h250);
    check("inv_value", 32'(value_out), 32'd250);
    check("inv_derr",  32'(digit_err), 32'h1);

    // Frame 999 -> overflow
    phase(3'b110, 7'h6F, 40);
    phase(3'b101, 7'h6F, 40);
    phase(3'b011, 7'h6F, 40);
    phase(3'b111, 7'h00, 40);
    check("ovf_vcnt",  32'(vcount),    32'd4);
    check("ovf_value", 32'(value_out), 32'd999);
    check("ovf_ovf",   32'(overflow),  32'h1);
    check("ovf_derr",  32'(digit_err), 32'h0);

    // Illegal select between partial captures: slots must be untouched
    phase(3'b110, 7'h66, 40);
    phase(3'b101, 7'h6D, 40);
    phase(3'b100, 7'h7F, 20);
    phase(3'b111, 7'h00, 40);
    check("illsel_pulses", 32'(secount), 32'd1);
    check("illsel_vcnt",   32'(vcount),  32'd4);
    phase(3'b011, 7'h06, 40);
    phase(3'b111, 7'h00, 40);
    check("illsel_frame_vcnt", 32'(vcount),    32'd5);
    check("illsel_frame_bcd",  32'(bcd_out),   32'h154);
    check("illsel_frame_ovf",  32'(overflow),  32'h0);

    // Reset mid-frame discards units/tens
    phase(3'b110, 7'h07, 40);
    phase(3'b101, 7'h7F, 40);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_bcd", 32'(bcd_out), 32'h0);
    phase(3'b011, 7'h7D, 40);
    phase(3'b111, 7'h00, 40);
    check("midrst_no_valid", 32'(vcount), 32'd5);
    phase(3'b110, 7'h66, 40);
    phase(3'b101, 7'h6D, 40);
    phase(3'b011, 7'h7D, 40);
    phase(3'b111, 7'h00, 40);
    check("midrst_vcnt",  32'(vcount),    32'd6);
    check("midrst_bcd2",  32'(bcd_out),   32'h654);
    check("midrst_value", 32'(value_out), 32'd654);
    check("midrst_ovf",   32'(overflow),  32'h1);
    check("valid_width",  32'(maxrun),    32'd1);
    check("selerr_total", 32'(secount),   32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seg7_scan_decoder.md
# seg7_scan_decoder

Receive-side block for the multiplexed 7-segment display bus: it samples the segment and digit-select lines produced by the BCD display driver and filters them for stability. It decodes each digit's segment pattern back to a BCD nibble, assembles hundreds/tens/units into a frame, and reports the binary value with a one-cycle valid strobe. It sits on the input pins of a monitor/loopback design and lets a bench or a second chip read back what the display shows.

## Interface
- STABLE_CYCLES, 16: consecutive identical synchronized samples required before a digit is captured (legal range 2..255).
- SEG_ACTIVE_LOW, 1: 1 means a lit segment is a 0 on seg_in; 0 means a lit segment is a 1.
- clk  input  1  system clock.
- rst  input  1  synchronous reset, active-high; one clock; reset is synchronous and active-high.
- seg_in  input  8  segment lines; bit0=a, bit1=b … bit6=g, bit7=DP (ignored).
- dig_sel_n  input  3  digit selects, active-low; 110=units, 101=tens, 011=hundreds, 111=blank.
- bcd_out  output  12  last complete frame {hundreds, tens, units}.
- value_out  output  10  binary value hundreds*100+tens*10+units (0..999).
- valid  output  1  one-cycle pulse when bcd_out/value_out update.
- digit_err  output  1  with valid: at least one digit of the frame had an undecodable pattern.
- overflow  output  1  with valid: value_out > 255.
- sel_err  output  1  one-cycle pulse on capture of an illegal select (two or more lows).

## Operation
- Input stage: seg_in[6:0] and dig_sel_n pass through a 2-flop synchronizer. Segments are normalized to active-high gfedcba when SEG_ACTIVE_LOW=1.
- Stability filter: compare the synced sample with the previous synced sample. On a mismatch the counter goes to 1; on a match it increments, saturating at STABLE_CYCLES.
- Capture FSM:
  - WAIT: when the counter reaches STABLE_CYCLES, capture once and go to HOLD.
  - HOLD: no recapture; return to WAIT on the first sample mismatch.
- Capture action by select:
  - Units, tens, hundreds: decode the pattern, write the nibble into that digit slot, set its seen bit, and set its err bit if the pattern is invalid (nibble stored as 0).
  - Blank (111): ignored.
  - Illegal select: ignored except for the sel_err pulse.
- Decode table (gfedcba hex): 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F. Every other value is invalid.
- Recapturing a digit already seen in the current frame overwrites its nibble and err bit (latest wins).
- Frame completion:
  - When all three seen bits are set after a capture, the next cycle registers bcd_out and value_out (computed as h*100+t*10+u, 10 bits, no truncation).
  - In the same cycle, digit_err = OR of the err bits, overflow = value_out > 255, and valid = 1.
  - The seen and err bits clear in the same cycle the frame is registered.
- Outputs other than the pulses hold their values between frames.

## Timing
- Reset values: bcd_out=0, value_out=0, valid=0, digit_err=0, overflow=0, sel_err=0. Synchronizer flops 0, counter 0, FSM in WAIT, seen/err bits 0.
- Reset mid-frame discards partial digits; the first valid after reset needs three fresh captures.
- Capture latency: an input change at edge N becomes a synced sample at N+2. Capture happens at edge N+1+STABLE_CYCLES if the input holds steady.
- valid asserts one cycle after the completing capture, for exactly one cycle. sel_err asserts one cycle after the illegal capture.
- A glitch shorter than STABLE_CYCLES synced cycles never captures. A return to the original value after a glitch re-arms and recaptures it, which is harmless because it overwrites with the same value.
- No back-pressure: valid is a pulse, and the consumer must sample it.
- Driver-side requirement: each digit phase must be ≥ STABLE_CYCLES+3 clocks. For the 16384-clock phase of the display driver this holds for all legal STABLE_CYCLES.

## Test plan
- Reset: hold rst 3 cycles → all outputs 0; release with no input activity → valid stays 0.
- Scan "123":
  - Stimulus: STABLE_CYCLES=16, phases of 40 cycles each: units sel 110 with pattern 4F, tens 101 with 5B, hundreds 011 with 06, then blank 111. All patterns inverted, SEG_ACTIVE_LOW=1.
  - Response: exactly one valid pulse; bcd_out=0x123, value_out=123, digit_err=0, overflow=0.
- Glitch rejection: within a units phase, drive pattern 7F for 5 cycles, then back to 4F → units digit remains 3; no extra valid.
- Invalid pattern: units pattern 0x49 in a frame with tens=5, hundreds=2 → valid with bcd_out=0x250, value_out=250, digit_err=1.
- Overflow / illegal select:
  - Frame 9,9,9 → value_out=999, overflow=1.
  - Select 100 held 20 cycles → one sel_err pulse; digit slots unchanged.
- Reset mid-frame: capture units and tens, assert rst 1 cycle, then scan only hundreds → no valid until a full new three-digit scan completes.
